// File: rtl/fb_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_mem_pkg                                                    |
// | Description : Shared definitions for the frame-buffer memory responder     |
// |               and the draw engines: request opcodes, responder state       |
// |               codes and frame-buffer geometry.                             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package fb_mem_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  localparam int FB_MEM_DEPTH  = 19200;
  // Words per frame-buffer row, shared with the draw engines.
  localparam int FB_ROW_STRIDE = 240;
  localparam int FB_ADDR_W     = 16;
  localparam int FB_DATA_W     = 32;

endpackage : fb_mem_pkg
`default_nettype wire

// File: rtl/fb_sram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_sram                                                       |
// | Description : Single-port synchronous frame-buffer RAM with per-byte write  |
// |               enables and a one-cycle registered read. No reset.           |
// | Ports       : clk            clock                                          |
// |               we / re        write / read enable                            |
// |               addr           word address (must be < DEPTH when enabled)    |
// |               wben           byte-lane write enables                        |
// |               wdata / rdata  write data / registered read data             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fb_sram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] wben,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Read data holds its value when no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wben[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule : fb_sram
`default_nettype wire

// File: rtl/fb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_mem_responder                                              |
// | Description : Responder end of the arbiter memory-request interface.       |
// |               Byte-enabled writes, pipelined reads returned on a broadcast |
// |               bus one cycle later, and a bulk clear sequencer.             |
// | Ports       : clk, rst_ (async, active-low)                                 |
// |               req_rts/req_rtr/req_op/req_addr/req_wben/req_data  request   |
// |               bcast_xfc/bcast_data/bcast_addr/bcast_err          read resp |
// |               clr_start/clr_value/clr_done                       clear     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fb_mem_responder
  import fb_mem_pkg::*;
#(
  parameter int MEM_DEPTH = FB_MEM_DEPTH,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                req_rts,
  output logic                req_rtr,
  input  logic                req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_wben,
  input  logic [DATA_W-1:0]   req_data,
  output logic                bcast_xfc,
  output logic [DATA_W-1:0]   bcast_data,
  output logic [ADDR_W-1:0]   bcast_addr,
  output logic                bcast_err,
  input  logic                clr_start,
  input  logic [DATA_W-1:0]   clr_value,
  output logic                clr_done
);

  localparam int                SRAM_AW   = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

  fb_state_e           state_q, state_d;
  logic                req_rtr_q, req_rtr_d;
  logic                bcast_xfc_q, bcast_xfc_d;
  logic [ADDR_W-1:0]   bcast_addr_q, bcast_addr_d;
  logic                bcast_err_q, bcast_err_d;
  logic                clr_done_q, clr_done_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   clr_value_q, clr_value_d;

  logic                xfc;
  logic                in_range;
  logic                sram_we;
  logic                sram_re;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [DATA_W/8-1:0] sram_wben;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_rdata;

  assign xfc      = req_rts & req_rtr_q;
  assign in_range = (req_addr <= LAST_ADDR);

  always_comb begin
    state_d      = state_q;
    bcast_xfc_d  = 1'b0;
    bcast_addr_d = bcast_addr_q;
    bcast_err_d  = 1'b0;
    clr_done_d   = 1'b0;
    clr_cnt_d    = clr_cnt_q;
    clr_value_d  = clr_value_q;
    sram_we      = 1'b0;
    sram_re      = 1'b0;
    sram_addr    = req_addr[SRAM_AW-1:0];
    sram_wben    = req_wben;
    sram_wdata   = req_data;

    case (state_q)
      ST_IDLE: begin
        // A request accepted alongside clr_start still executes; the clear
        // starts in the following cycle.
        if (xfc) begin
          if (req_op == OP_READ) begin
            bcast_xfc_d  = 1'b1;
            bcast_addr_d = req_addr;
            bcast_err_d  = ~in_range;
            sram_re      = in_range;
          end else begin
            // Out-of-range writes are dropped without any indication.
            sram_we = in_range;
          end
        end
        if (clr_start) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = '0;
          clr_value_d = clr_value;
        end
      end
      ST_CLEAR: begin
        sram_we    = 1'b1;
        sram_addr  = clr_cnt_q[SRAM_AW-1:0];
        sram_wben  = '1;
        sram_wdata = clr_value_q;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_cnt_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered ready: follows the state being entered, so it is low in the
    // first cycle out of reset and for every clear cycle.
    req_rtr_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= ST_IDLE;
      req_rtr_q    <= 1'b0;
      bcast_xfc_q  <= 1'b0;
      bcast_addr_q <= '0;
      bcast_err_q  <= 1'b0;
      clr_done_q   <= 1'b0;
      clr_cnt_q    <= '0;
      clr_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_rtr_q    <= req_rtr_d;
      bcast_xfc_q  <= bcast_xfc_d;
      bcast_addr_q <= bcast_addr_d;
      bcast_err_q  <= bcast_err_d;
      clr_done_q   <= clr_done_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_value_q  <= clr_value_d;
    end
  end

  fb_sram #(
    .DEPTH (MEM_DEPTH),
    .AW    (SRAM_AW),
    .DW    (DATA_W)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .re    (sram_re),
    .addr  (sram_addr),
    .wben  (sram_wben),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  assign req_rtr    = req_rtr_q;
  assign bcast_xfc  = bcast_xfc_q;
  assign bcast_addr = bcast_addr_q;
  assign bcast_err  = bcast_err_q;
  assign clr_done   = clr_done_q;
  // The SRAM output register is not reset, so the data bus is gated to zero
  // except on a valid, in-range response.
  assign bcast_data = (bcast_xfc_q && !bcast_err_q) ? sram_rdata : '0;

endmodule : fb_mem_responder
`default_nettype wire

// File: tb/tb_fb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_fb_mem_responder                                           |
// | Description : Directed self-checking bench for fb_mem_responder.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fb_mem_responder;
  import fb_mem_pkg::*;

  logic        clk;
  logic        rst_;
  logic        req_rts;
  logic        req_rtr;
  logic        req_op;
  logic [15:0] req_addr;
  logic [3:0]  req_wben;
  logic [31:0] req_data;
  logic        bcast_xfc;
  logic [31:0] bcast_data;
  logic [15:0] bcast_addr;
  logic        bcast_err;
  logic        clr_start;
  logic [31:0] clr_value;
  logic        clr_done;

  int pass_cnt;
  int total_cnt;

  fb_mem_responder dut (
    .clk        (clk),
    .rst_       (rst_),
    .req_rts    (req_rts),
    .req_rtr    (req_rtr),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wben   (req_wben),
    .req_data   (req_data),
    .bcast_xfc  (bcast_xfc),
    .bcast_data (bcast_data),
    .bcast_addr (bcast_addr),
    .bcast_err  (bcast_err),
    .clr_start  (clr_start),
    .clr_value  (clr_value),
    .clr_done   (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1, "watchdog expired");
  end

  // Drive helpers: called at a negedge, return at the next negedge.
  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    req_rts = 1'b1; req_op = OP_WRITE; req_addr = a; req_data = d; req_wben = be;
    @(negedge clk);
    req_rts = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic x, output logic [31:0] d,
                         output logic [15:0] ra, output logic e);
    req_rts = 1'b1; req_op = OP_READ; req_addr = a; req_wben = 4'h0;
    @(negedge clk);
    x = bcast_xfc; d = bcast_data; ra = bcast_addr; e = bcast_err;
    req_rts = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({req_rtr, bcast_xfc, bcast_err, clr_done} !== 4'b0000 || bcast_data !== 32'h0 || bcast_addr !== 16'h0)
      $display("FAIL reset_outputs: rtr=%b xfc=%b err=%b done=%b data=%h addr=%h, required all zero",
               req_rtr, bcast_xfc, bcast_err, clr_done, bcast_data, bcast_addr);
    else pass_cnt++;
    rst_ = 1'b1;
    #1;
    total_cnt++;
    if (req_rtr !== 1'b0) $display("FAIL rtr_after_release: got %b required 0", req_rtr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (req_rtr !== 1'b1) $display("FAIL rtr_idle: got %b required 1", req_rtr);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    logic x, e; logic [31:0] d; logic [15:0] a;
    do_write(16'h0010, 32'hA5A5_A5A5, 4'hF);
    do_read(16'h0010, x, d, a, e);
    total_cnt++;
    if ({x, e} !== 2'b10 || d !== 32'hA5A5_A5A5 || a !== 16'h0010)
      $display("FAIL write_read: xfc=%b err=%b data=%h addr=%h, required 1 0 a5a5a5a5 0010", x, e, d, a);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bcast_xfc !== 1'b0) $display("FAIL bcast_strobe_width: got %b required 0", bcast_xfc);
    else pass_cnt++;
  endtask

  task automatic test_wben();
    logic x, e; logic [31:0] d; logic [15:0] a;
    do_write(16'h0020, 32'h1234_5678, 4'hF);
    do_write(16'h0020, 32'hFFFF_FFFF, 4'b0101);
    do_read(16'h0020, x, d, a, e);
    total_cnt++;
    if (x !== 1'b1 || d !== 32'h12FF_56FF)
      $display("FAIL wben_merge: xfc=%b data=%h, required 1 12ff56ff", x, d);
    else pass_cnt++;
    do_write(16'h0020, 32'h0000_0000, 4'b0000);
    do_read(16'h0020, x, d, a, e);
    total_cnt++;
    if (d !== 32'h12FF_56FF) $display("FAIL wben_zero_noop: got %h required 12ff56ff", d);
    else pass_cnt++;
    do_write(16'h0020, 32'hABCD_EF01, 4'b1010);
    do_read(16'h0020, x, d, a, e);
    total_cnt++;
    if (d !== 32'hABFF_EFFF) $display("FAIL wben_upper_lanes: got %h required abffefff", d);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic x, e; logic [31:0] d; logic [15:0] a;
    do_write(16'd19199, 32'hDEAD_BEEF, 4'hF);
    do_write(16'd19200, 32'h1111_1111, 4'hF);
    do_read(16'd19200, x, d, a, e);
    total_cnt++;
    if ({x, e} !== 2'b11 || d !== 32'h0 || a !== 16'd19200)
      $display("FAIL oor_read: xfc=%b err=%b data=%h addr=%0d, required 1 1 00000000 19200", x, e, d, a);
    else pass_cnt++;
    do_read(16'd19199, x, d, a, e);
    total_cnt++;
    if ({x, e} !== 2'b10 || d !== 32'hDEAD_BEEF || a !== 16'd19199)
      $display("FAIL last_addr_intact: xfc=%b err=%b data=%h addr=%0d, required 1 0 deadbeef 19199", x, e, d, a);
    else pass_cnt++;
    do_read(16'hFFFF, x, d, a, e);
    total_cnt++;
    if ({x, e} !== 2'b11 || d !== 32'h0)
      $display("FAIL oor_max_addr: xfc=%b err=%b data=%h, required 1 1 00000000", x, e, d);
    else pass_cnt++;
  endtask

  task automatic test_write_then_read();
    do_write(16'h0030, 32'h0BAD_CAFE, 4'hF);
    // Read of the same address in the very next cycle.
    req_rts = 1'b1; req_op = OP_WRITE; req_addr = 16'h0030; req_data = 32'h7654_3210; req_wben = 4'hF;
    @(negedge clk);
    req_op = OP_READ;
    @(negedge clk);
    req_rts = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bcast_xfc !== 1'b0) $display("FAIL raw_no_extra_strobe: got %b required 0", bcast_xfc);
    else pass_cnt++;
    req_rts = 1'b1; req_op = OP_WRITE; req_data = 32'hCAFE_0001;
    @(negedge clk);
    req_op = OP_READ;
    @(negedge clk);
    req_rts = 1'b0;
    total_cnt++;
    if (bcast_xfc !== 1'b1 || bcast_data !== 32'hCAFE_0001)
      $display("FAIL raw_new_data: xfc=%b data=%h, required 1 cafe0001", bcast_xfc, bcast_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int i = 1; i <= 4; i++) do_write(16'(i), 32'hB0B0_0000 + 32'(i), 4'hF);
    req_rts = 1'b1; req_op = OP_READ; req_addr = 16'd1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exp_d = 32'hB0B0_0000 + 32'(i);
      total_cnt++;
      if (bcast_xfc !== 1'b1 || bcast_addr !== 16'(i) || bcast_data !== exp_d)
        $display("FAIL b2b_read_%0d: xfc=%b addr=%0d data=%h, required 1 %0d %h",
                 i, bcast_xfc, bcast_addr, bcast_data, i, exp_d);
      else pass_cnt++;
      req_addr = 16'(i + 1);
    end
    req_rts = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    logic x, e; logic [31:0] d; logic [15:0] a;
    int low_cnt, done_cnt;
    logic seen_idle;
    do_write(16'd0, 32'h0BAD_F00D, 4'hF);
    do_write(16'd240, 32'h0000_F0F0, 4'hF);
    // Read accepted in the same cycle as clr_start.
    clr_start = 1'b1; clr_value = 32'h0000_0000;
    req_rts = 1'b1; req_op = OP_READ; req_addr = 16'd240;
    @(negedge clk);
    req_rts = 1'b0; clr_start = 1'b0;
    clr_value = 32'hFFFF_FFFF;
    total_cnt++;
    if (bcast_xfc !== 1'b1 || bcast_data !== 32'h0000_F0F0 || req_rtr !== 1'b0)
      $display("FAIL clear_with_read: xfc=%b data=%h rtr=%b, required 1 0000f0f0 0", bcast_xfc, bcast_data, req_rtr);
    else pass_cnt++;
    low_cnt = 0; done_cnt = 0; seen_idle = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (i > 0) @(negedge clk);
      clr_start = (i == 50);
      if (clr_done === 1'b1) done_cnt++;
      if (req_rtr === 1'b1) begin
        seen_idle = 1'b1;
        break;
      end
      low_cnt++;
    end
    clr_start = 1'b0;
    total_cnt++;
    if (!seen_idle || low_cnt != 19200)
      $display("FAIL clear_rtr_low_cycles: got %0d (ended=%b) required 19200", low_cnt, seen_idle);
    else pass_cnt++;
    total_cnt++;
    if (clr_done !== 1'b1) $display("FAIL clr_done_with_idle: got %b required 1", clr_done);
    else pass_cnt++;
    repeat (3) begin
      @(negedge clk);
      if (clr_done === 1'b1) done_cnt++;
    end
    total_cnt++;
    if (done_cnt != 1) $display("FAIL clr_done_pulses: got %0d required 1", done_cnt);
    else pass_cnt++;
    do_read(16'd0, x, d, a, e);
    total_cnt++;
    if (x !== 1'b1 || d !== 32'h0) $display("FAIL cleared_addr0: xfc=%b data=%h, required 1 00000000", x, d);
    else pass_cnt++;
    do_read(16'(FB_ROW_STRIDE), x, d, a, e);
    total_cnt++;
    if (x !== 1'b1 || d !== 32'h0) $display("FAIL cleared_addr240: xfc=%b data=%h, required 1 00000000", x, d);
    else pass_cnt++;
    do_read(16'd19199, x, d, a, e);
    total_cnt++;
    if (x !== 1'b1 || d !== 32'h0) $display("FAIL cleared_addr19199: xfc=%b data=%h, required 1 00000000", x, d);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic x, e; logic [31:0] d; logic [15:0] a;
    int done_cnt;
    do_write(16'd5, 32'h1212_1212, 4'hF);
    do_write(16'd256, 32'h7777_7777, 4'hF);
    clr_start = 1'b1; clr_value = 32'h5A5A_5A5A;
    @(negedge clk);
    clr_start = 1'b0;
    done_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (clr_done === 1'b1) done_cnt++;
    end
    rst_ = 1'b0;
    #1;
    total_cnt++;
    if ({req_rtr, bcast_xfc, bcast_err, clr_done} !== 4'b0000 || bcast_data !== 32'h0 || bcast_addr !== 16'h0)
      $display("FAIL reset_mid_clear: rtr=%b xfc=%b err=%b done=%b data=%h addr=%h, required all zero",
               req_rtr, bcast_xfc, bcast_err, clr_done, bcast_data, bcast_addr);
    else pass_cnt++;
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    total_cnt++;
    if (req_rtr !== 1'b0) $display("FAIL rtr_after_mid_reset: got %b required 0", req_rtr);
    else pass_cnt++;
    repeat (3) begin
      @(negedge clk);
      if (clr_done === 1'b1) done_cnt++;
    end
    total_cnt++;
    if (req_rtr !== 1'b1 || done_cnt != 0)
      $display("FAIL clear_abandoned: rtr=%b done_pulses=%0d, required 1 0", req_rtr, done_cnt);
    else pass_cnt++;
    do_read(16'd5, x, d, a, e);
    total_cnt++;
    if (d !== 32'h5A5A_5A5A) $display("FAIL partial_clear_low: got %h required 5a5a5a5a", d);
    else pass_cnt++;
    do_read(16'd256, x, d, a, e);
    total_cnt++;
    if (d !== 32'h7777_7777) $display("FAIL partial_clear_high: got %h required 77777777", d);
    else pass_cnt++;
    // Reset while a read response is on the bus.
    req_rts = 1'b1; req_op = OP_READ; req_addr = 16'd5;
    @(posedge clk);
    #1;
    req_rts = 1'b0;
    total_cnt++;
    if (bcast_xfc !== 1'b1) $display("FAIL inflight_read_strobe: got %b required 1", bcast_xfc);
    else pass_cnt++;
    rst_ = 1'b0;
    #1;
    total_cnt++;
    if (bcast_xfc !== 1'b0 || bcast_data !== 32'h0) $display("FAIL reset_mid_read: xfc=%b data=%h, required 0 00000000", bcast_xfc, bcast_data);
    else pass_cnt++;
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_ = 1'b0; req_rts = 1'b0; req_op = OP_WRITE; req_addr = '0; req_wben = '0;
    req_data = '0; clr_start = 1'b0; clr_value = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_wben();
    test_out_of_range();
    test_write_then_read();
    test_back_to_back();
    test_clear();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_fb_mem_responder
`default_nettype wire
